pkt_collector: RTL
==================

# pkt_collector

Downstream receive stage for the serial packet router. Captures the four gated serial output ports and their shared frame-valid strobe, deserialises each 64-bit frame MSB-first, records which port(s) carried data, and queues complete frames in a small FIFO. The FIFO drains to the host-side consumer over a valid/ready stream. Truncated frames and frames that arrive while the FIFO is full are discarded and counted.

## Interface
- `PKT_BITS`, 64: frame length in bits.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `valid_in` input 1: frame strobe; one serial bit per cycle while high.
- `port_in` input 4: serial bits of ports 1..4 (bit0 = port1).
- `m_valid` output 1: FIFO head holds a frame.
- `m_ready` input 1: consumer accepts head.
- `m_data` output PKT_BITS: head frame, first-received bit in MSB.
- `m_mask` output 4: head frame port-activity mask.
- `m_err` output 1: head frame had more than one mask bit set.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.
- `drop_cnt` output 8: frames dropped because the FIFO was full (saturating).
- `trunc_cnt` output 8: frames aborted early (saturating).

## Operation
- Sampled bit = OR of `port_in[3:0]`. The shift register shifts left and inserts the bit at the LSB.
- Mask register: per-port sticky OR of `port_in` over the frame.
- Bit counter width is $clog2(PKT_BITS)+1.
- FSM states:
  - IDLE: on `valid_in`=1, go to RECV. Capture bit 1, set mask to `port_in`, set counter to 1.
  - RECV with `valid_in`=1: capture the bit and increment the counter. When the captured bit is bit PKT_BITS, push the frame `{data, mask, err}` and return to IDLE.
  - RECV with `valid_in`=0 and counter < PKT_BITS: discard the frame, increment `trunc_cnt`, go to IDLE.
- Back-to-back frames: if `valid_in` stays high, the cycle after the last bit is bit 1 of the next frame. It is captured from IDLE with no gap.
- An all-zero frame is valid: `m_data`=0, `m_mask`=0, `m_err`=0.
- `m_err` = popcount(mask) > 1.
- Push rules:
  - A push is accepted when `level` < DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the frame is discarded and `drop_cnt` increments.
- Pop occurs when `m_valid` && `m_ready`.
- FIFO pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave `level` unchanged.
- `m_data`, `m_mask` and `m_err` hold stable while `m_valid`=1 and `m_ready`=0.

## Timing
- Reset values: FSM=IDLE, counter=0, shift register=0, mask=0, FIFO empty, `m_valid`=0, `m_data`=0, `m_mask`=0, `m_err`=0, `level`=0, `drop_cnt`=0, `trunc_cnt`=0.
- Reset in mid-frame aborts the frame and does not count it. FIFO contents are lost.
- Latency: last bit sampled at edge N; `m_valid`=1 and `level` updated after edge N when the FIFO was empty. Head data is registered FIFO output, with no combinational path from `port_in`.
- `m_valid` depends only on registered state. `m_ready` can be asserted before `m_valid`.
- Counters saturate at 255 and never wrap.
- A truncation and a new `valid_in` rising cannot coincide, because truncation requires `valid_in`=0.

## Configuration
- Macro: `PKT_COLLECT_STATS_EN`.
- Defined: `drop_cnt` and `trunc_cnt` are implemented as specified.
- Undefined: both counter registers are absent and the outputs are tied to 0. Drop and truncation discard behaviour is unchanged.

## Test plan
- Frame on port1, `valid_in` high 64 cycles, pattern 64'hDEAD_BEEF_0123_4567 -> one entry: `m_data`=64'hDEAD_BEEF_0123_4567, `m_mask`=4'b0001, `m_err`=0; `m_valid` rises the cycle after the last bit.
- Two back-to-back frames (128 continuous valid cycles) on port3, with `m_ready`=0 -> `level`=2. Popping returns both frames in order with `m_mask`=4'b0100.
- `valid_in` drops after 40 bits, then a full frame follows -> `trunc_cnt`=1; only the full frame is queued.
- `m_ready`=0, DEPTH+2 frames sent -> `level`=DEPTH, `drop_cnt`=2. The first DEPTH frames are intact.
- Full FIFO with a pop on the same edge as the push -> frame accepted, `level` stays at DEPTH, `drop_cnt` unchanged.
- Frame with ones on both port2 and port4 -> `m_mask`=4'b1010, `m_err`=1. Reset asserted mid-frame -> all outputs return to reset values and no counter increments.

Source files
------------

// File: rtl/pkt_collector_if.sv
// pkt_collector_if: serial frame input, host-side frame stream and status counters of pkt_collector.
interface pkt_collector_if #(
    parameter int PKT_BITS = 64,
    parameter int DEPTH    = 4
);
    logic                      valid_in;
    logic [3:0]                port_in;
    logic                      m_valid;
    logic                      m_ready;
    logic [PKT_BITS-1:0]       m_data;
    logic [3:0]                m_mask;
    logic                      m_err;
    logic [$clog2(DEPTH):0]    level;
    logic [7:0]                drop_cnt;
    logic [7:0]                trunc_cnt;

    modport master (
        output valid_in, port_in, m_ready,
        input  m_valid, m_data, m_mask, m_err, level, drop_cnt, trunc_cnt
    );
    modport slave (
        input  valid_in, port_in, m_ready,
        output m_valid, m_data, m_mask, m_err, level, drop_cnt, trunc_cnt
    );
endinterface

// File: rtl/pkt_collector.sv
// pkt_collector: deserialises 4-port framed serial data into a FIFO drained over valid/ready.
// Define PKT_COLLECT_STATS_EN to implement the saturating drop/truncation counters.
module pkt_collector #(
    parameter int PKT_BITS = 64,
    parameter int DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    pkt_collector_if.slave bus
);
    localparam int CW = $clog2(PKT_BITS) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [PKT_BITS-2:0] shift_q;
    logic [PKT_BITS-1:0] shift_d;
    logic [3:0]          mask_q, mask_d;
    logic [AW-1:0]       wr_q, rd_q;
    logic [LW-1:0]       level_q, level_d;
    logic [PKT_BITS-1:0] data_q [DEPTH];
    logic [3:0]          mmask_q [DEPTH];
    logic                err_q [DEPTH];
    logic                push, pop, push_ok;

    always_comb begin
        shift_d = {shift_q, |bus.port_in};
        mask_d  = (state_q == IDLE ? 4'b0 : mask_q) | bus.port_in;
        push    = state_q == RECV && bus.valid_in && cnt_q == CW'(PKT_BITS - 1);
        pop     = level_q != '0 && bus.m_ready;
        // a simultaneous pop frees the slot the push needs
        push_ok = push && (level_q != FULL || pop);
        level_d = level_q + LW'(push_ok) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            mask_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                mmask_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            state_q <= bus.valid_in && !push ? RECV : IDLE;
            cnt_q   <= bus.valid_in && !push ? cnt_q + CW'(1) : '0;
            if (bus.valid_in) begin
                shift_q <= shift_d[PKT_BITS-2:0];
                mask_q  <= mask_d;
            end
            if (push_ok) begin
                data_q[wr_q]  <= shift_d;
                mmask_q[wr_q] <= mask_d;
                err_q[wr_q]   <= |(mask_d & (mask_d - 4'd1));
                wr_q          <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            level_q <= level_d;
        end
    end

    assign bus.m_valid = level_q != '0;
    assign bus.m_data  = data_q[rd_q];
    assign bus.m_mask  = mmask_q[rd_q];
    assign bus.m_err   = err_q[rd_q];
    assign bus.level   = level_q;

`ifdef PKT_COLLECT_STATS_EN
    logic [7:0] drop_q, trunc_q;
    logic       drop, trunc;

    assign drop  = push && !push_ok;
    assign trunc = state_q == RECV && !bus.valid_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_q  <= '0;
            trunc_q <= '0;
        end else begin
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (trunc && trunc_q != 8'hFF) trunc_q <= trunc_q + 8'd1;
        end
    end

    assign bus.drop_cnt  = drop_q;
    assign bus.trunc_cnt = trunc_q;
`else
    assign bus.drop_cnt  = '0;
    assign bus.trunc_cnt = '0;
`endif
endmodule
